// File: rtl/emu_ff_ckpt_engine.sv
`default_nettype none
// ============================================================================
// Module   : emu_ff_ckpt_engine
// Purpose  : Halts the emulated DUT and scans its FF chain to dump, restore or
//            swap checkpoint slots held in an internal word memory.
// Revision : 1.0  initial release
// ============================================================================
module emu_ff_ckpt_engine #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHAIN_BEATS = 3,
  parameter int SLOTS       = 4,
  parameter int SLOT_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  parameter int ADDR_W      = (SLOTS * CHAIN_BEATS > 1) ? $clog2(SLOTS * CHAIN_BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [SLOT_W-1:0]     cmd_src,
  input  logic [SLOT_W-1:0]     cmd_dst,
  input  logic                  cmd_hold,
  input  logic                  resume,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic                  halted,
  output logic                  halt_o,
  output logic                  ff_scan,
  output logic [DATA_WIDTH-1:0] ff_sdi,
  input  logic [DATA_WIDTH-1:0] ff_sdo,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int c_depth  = SLOTS * CHAIN_BEATS;
  localparam int c_beat_w = (CHAIN_BEATS > 1) ? $clog2(CHAIN_BEATS) : 1;
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(CHAIN_BEATS - 1);

  localparam logic [1:0] c_op_dump    = 2'd0;
  localparam logic [1:0] c_op_restore = 2'd1;
  localparam logic [1:0] c_op_swap    = 2'd2;
  localparam logic [1:0] c_op_rsvd    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_SCAN = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_beat_w-1:0]   r_beat;
  logic [1:0]            r_op;
  logic [SLOT_W-1:0]     r_src;
  logic [SLOT_W-1:0]     r_dst;
  logic                  r_hold;
  logic                  r_halted;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  logic                  w_accept;
  logic                  w_uses_src;
  logic                  w_uses_dst;
  logic                  w_bad;
  logic                  w_start;
  logic                  w_last;
  logic                  w_capture;
  logic                  w_host_ok;
  logic [ADDR_W-1:0]     w_src_idx;
  logic [ADDR_W-1:0]     w_dst_idx;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_uses_src = (cmd_op == c_op_restore) || (cmd_op == c_op_swap);
  assign w_uses_dst = (cmd_op == c_op_dump) || (cmd_op == c_op_swap);
  assign w_bad      = (cmd_op == c_op_rsvd)
                   || (w_uses_src && (32'(cmd_src) >= 32'(SLOTS)))
                   || (w_uses_dst && (32'(cmd_dst) >= 32'(SLOTS)));
  assign w_start    = w_accept && !w_bad;
  assign w_last     = (r_beat == c_last_beat);

  assign w_src_idx  = ADDR_W'(32'(r_src) * 32'(CHAIN_BEATS) + 32'(r_beat));
  assign w_dst_idx  = ADDR_W'(32'(r_dst) * 32'(CHAIN_BEATS) + 32'(r_beat));
  assign w_capture  = (r_state == S_SCAN) && (r_op != c_op_restore);
  assign w_host_ok  = mem_en && (r_state == S_IDLE) && (32'(mem_addr) < 32'(c_depth));

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    ff_scan   = 1'b0;
    done      = 1'b0;
    halt_o    = 1'b1;
    ff_sdi    = '0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        halt_o    = r_halted;
        if (w_start) begin
          w_next = S_PREP;
        end
      end
      S_PREP: begin
        w_next = S_SCAN;
      end
      S_SCAN: begin
        ff_scan = 1'b1;
        // Loopback keeps the chain intact while a DUMP reads it out.
        ff_sdi  = (r_op == c_op_dump) ? ff_sdo : r_mem[w_src_idx];
        if (w_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        done   = 1'b1;
        halt_o = r_halted;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_op     <= c_op_dump;
      r_src    <= '0;
      r_dst    <= '0;
      r_hold   <= 1'b0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && w_bad;
      if (w_start) begin
        r_op     <= cmd_op;
        r_src    <= cmd_src;
        r_dst    <= cmd_dst;
        r_hold   <= cmd_hold;
        r_halted <= 1'b0;
      end else if ((r_state == S_IDLE) && resume) begin
        r_halted <= 1'b0;
      end else if ((r_state == S_SCAN) && w_last) begin
        r_halted <= r_hold;
      end
      if (r_state == S_SCAN) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
    end
  end

  // Slot contents survive reset; only the access paths are gated by it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_host_ok && mem_we) begin
        r_mem[mem_addr] <= mem_wdata;
      end
      if (w_capture) begin
        r_mem[w_dst_idx] <= ff_sdo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_host_ok && !mem_we) begin
      r_rdata <= r_mem[mem_addr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign err       = r_err;
  assign halted    = r_halted;
  assign mem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_emu_ff_ckpt_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_ff_ckpt_engine
// Purpose  : Directed bench for the checkpoint engine with a shift-chain model.
// Revision : 1.0  initial release
// ============================================================================
module tb_emu_ff_ckpt_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_hold, resume;
  logic [1:0]  cmd_op, cmd_src, cmd_dst;
  logic        done, err, busy, halted, halt_o, ff_scan;
  logic [63:0] ff_sdi, ff_sdo;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  logic        b_valid, b_ready, b_done, b_err, b_busy, b_halted, b_halt, b_scan;
  logic [1:0]  b_op;
  logic [2:0]  b_src, b_dst;
  logic [63:0] b_sdi, b_rdata;
  logic [63:0] b_sdo = 64'h0;

  logic [63:0] chain [3];
  logic [63:0] load_val [3];
  logic        load_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  emu_ff_ckpt_engine #(.DATA_WIDTH(64), .CHAIN_BEATS(3), .SLOTS(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_hold(cmd_hold),
    .resume(resume), .done(done), .err(err), .busy(busy), .halted(halted),
    .halt_o(halt_o), .ff_scan(ff_scan), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  emu_ff_ckpt_engine #(.DATA_WIDTH(64), .CHAIN_BEATS(3), .SLOTS(5)) dut5 (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_src(b_src), .cmd_dst(b_dst), .cmd_hold(1'b0),
    .resume(1'b0), .done(b_done), .err(b_err), .busy(b_busy), .halted(b_halted),
    .halt_o(b_halt), .ff_scan(b_scan), .ff_sdi(b_sdi), .ff_sdo(b_sdo),
    .mem_en(1'b0), .mem_we(1'b0), .mem_addr(4'd0),
    .mem_wdata(64'h0), .mem_rdata(b_rdata)
  );

  // Chain model: beat 0 leaves on SDO, SDI enters at the tail.
  assign ff_sdo = chain[0];
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 3; i++) chain[i] <= load_val[i];
    end else if (ff_scan) begin
      chain[0] <= chain[1];
      chain[1] <= chain[2];
      chain[2] <= ff_sdi;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chain(input logic [63:0] v0, v1, v2);
    load_val[0] = v0; load_val[1] = v1; load_val[2] = v2;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [63:0] d);
    mem_en = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_en = 1'b0; mem_we = 1'b0;
  endtask

  task automatic host_read_chk(input string tag, input logic [3:0] a, input logic [63:0] exp);
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = a;
    tick();
    mem_en = 1'b0;
    chk(tag, mem_rdata, exp);
  endtask

  // Issues a command and observes 8 cycles; any pending host access rides on the accept edge.
  task automatic run(input logic [1:0] op, src, dst, input logic hold,
                     output int halt_n, output int scan_n, output int done_at);
    halt_n = 0; scan_n = 0; done_at = -1;
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_hold = hold; cmd_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) begin
        cmd_valid = 1'b0;
        mem_en = 1'b0; mem_we = 1'b0;
      end
      if (halt_o) halt_n++;
      if (ff_scan) scan_n++;
      if (done && done_at < 0) done_at = n;
    end
  endtask

  initial begin
    logic [63:0] a [3];
    logic [63:0] x [3];
    logic [63:0] y [3];
    int hn, sn, dn;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = 2'd0; cmd_dst = 2'd0;
    cmd_hold = 1'b0; resume = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mem_addr = 4'd0;
    mem_wdata = 64'h0; load_en = 1'b0;
    b_valid = 1'b0; b_op = 2'd0; b_src = 3'd0; b_dst = 3'd0;
    for (int i = 0; i < 3; i++) begin
      a[i] = {$urandom, $urandom};
      x[i] = {$urandom, $urandom};
      y[i] = {$urandom, $urandom};
      load_val[i] = 64'h0;
    end
    tick(); tick();
    rst = 1'b0;

    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done_err", {done, err}, 2'b00);
    chk("rst_halt", {halted, halt_o, ff_scan}, 3'b000);
    chk("rst_rdata", mem_rdata, 64'h0);
    chk("rst_sdi", ff_sdi, 64'h0);

    // DUMP slot 2, no hold
    load_chain(a[0], a[1], a[2]);
    run(2'd0, 2'd0, 2'd2, 1'b0, hn, sn, dn);
    chk("dump_halt_cycles", 64'(hn), 64'd4);
    chk("dump_scan_cycles", 64'(sn), 64'd3);
    chk("dump_done_cycle", 64'(dn), 64'd5);
    chk("dump_halted", halted, 1'b0);
    for (int i = 0; i < 3; i++) chk("dump_chain_kept", chain[i], a[i]);
    host_read_chk("dump_mem6", 4'd6, a[0]);
    host_read_chk("dump_mem7", 4'd7, a[1]);
    host_read_chk("dump_mem8", 4'd8, a[2]);

    // DUMP slot 0, overwrite chain, RESTORE slot 0 with hold
    run(2'd0, 2'd0, 2'd0, 1'b0, hn, sn, dn);
    load_chain(x[0], x[1], x[2]);
    run(2'd1, 2'd0, 2'd0, 1'b1, hn, sn, dn);
    for (int i = 0; i < 3; i++) chk("restore_chain", chain[i], a[i]);
    chk("hold_halted", halted, 1'b1);
    chk("hold_halt_o", halt_o, 1'b1);
    chk("hold_ready", cmd_ready, 1'b1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halt_o", halt_o, 1'b0);
    chk("resume_halted", halted, 1'b0);

    // Host-loaded slot 1 restored into the chain
    host_write(4'd3, 64'h1111_1111_1111_1111);
    host_write(4'd4, 64'h2222_2222_2222_2222);
    host_write(4'd5, 64'h3333_3333_3333_3333);
    run(2'd1, 2'd1, 2'd0, 1'b0, hn, sn, dn);
    chk("r1_chain0", chain[0], 64'h1111_1111_1111_1111);
    chk("r1_chain1", chain[1], 64'h2222_2222_2222_2222);
    chk("r1_chain2", chain[2], 64'h3333_3333_3333_3333);
    host_read_chk("r1_read4", 4'd4, 64'h2222_2222_2222_2222);
    tick();
    chk("read_clears", mem_rdata, 64'h0);
    host_read_chk("read_oob", 4'd12, 64'h0);

    // SWAP with src == dst exchanges chain and slot
    load_chain(x[0], x[1], x[2]);
    for (int i = 0; i < 3; i++) host_write(4'(9 + i), y[i]);
    run(2'd2, 2'd3, 2'd3, 1'b0, hn, sn, dn);
    for (int i = 0; i < 3; i++) chk("swap33_chain", chain[i], y[i]);
    for (int i = 0; i < 3; i++) host_read_chk("swap33_slot", 4'(9 + i), x[i]);

    // SWAP src 1 dst 2: chain gets slot 1, slot 2 gets chain, slot 1 kept
    run(2'd2, 2'd1, 2'd2, 1'b0, hn, sn, dn);
    chk("swap12_chain0", chain[0], 64'h1111_1111_1111_1111);
    chk("swap12_chain2", chain[2], 64'h3333_3333_3333_3333);
    host_read_chk("swap12_src_kept", 4'd4, 64'h2222_2222_2222_2222);
    for (int i = 0; i < 3; i++) host_read_chk("swap12_dst", 4'(6 + i), y[i]);

    // Host write on the accept edge lands before the restore reads it
    mem_en = 1'b1; mem_we = 1'b1; mem_addr = 4'd0; mem_wdata = 64'hDEAD_BEEF_0000_0001;
    run(2'd1, 2'd0, 2'd0, 1'b0, hn, sn, dn);
    chk("wr_then_cmd_b0", chain[0], 64'hDEAD_BEEF_0000_0001);
    chk("wr_then_cmd_b1", chain[1], a[1]);

    // Rejects
    cmd_op = 2'd3; cmd_src = 2'd0; cmd_dst = 2'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("rej_err", err, 1'b1);
    chk("rej_halt_scan", {halt_o, ff_scan}, 2'b00);
    chk("rej_ready", cmd_ready, 1'b1);
    tick();
    chk("rej_err_pulse", err, 1'b0);

    b_op = 2'd0; b_dst = 3'd5; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("rej5_err", b_err, 1'b1);
    chk("rej5_state", {b_busy, b_halt, b_scan, b_ready}, 4'b0001);
    b_op = 2'd1; b_src = 3'd7; b_dst = 3'd0; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("rej7_src_err", b_err, 1'b1);
    b_op = 2'd0; b_src = 3'd0; b_dst = 3'd4; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("acc4_err", b_err, 1'b0);
    chk("acc4_busy", {b_busy, b_halt}, 2'b11);
    for (int i = 0; i < 5; i++) tick();
    chk("acc4_idle", b_ready, 1'b1);

    // Reset during SCAN beat 1; host accesses while busy
    host_write(4'd1, 64'h0000_0000_CAFE_F00D);
    cmd_op = 2'd1; cmd_src = 2'd1; cmd_dst = 2'd0; cmd_hold = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    mem_en = 1'b1; mem_we = 1'b1; mem_addr = 4'd1; mem_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_we = 1'b0; mem_addr = 4'd3;
    tick();
    mem_en = 1'b0;
    chk("busy_read_zero", mem_rdata, 64'h0);
    chk("scan_b1", {busy, ff_scan}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outs", {halt_o, ff_scan, busy, done}, 4'b0000);
    chk("abort_ready", cmd_ready, 1'b1);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    host_read_chk("busy_write_dropped", 4'd1, 64'h0000_0000_CAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
